// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: power-up/init handshake with the mouse, then
// 3-byte movement packet assembly with a one-cycle publish interrupt.
module mouse_master_sm #(
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned RESP_TIMEOUT   = 50000000,
  parameter int unsigned PKT_TIMEOUT    = 200000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BYTE_SENT,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  output logic       READ_ENABLE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] RETRY_COUNT,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    PWRUP       = 4'd0,
    SEND_RST    = 4'd1,
    WAIT_TX_RST = 4'd2,
    WAIT_FA     = 4'd3,
    WAIT_AA     = 4'd4,
    WAIT_ID     = 4'd5,
    SEND_EN     = 4'd6,
    WAIT_TX_EN  = 4'd7,
    WAIT_FA_EN  = 4'd8,
    STRM_B1     = 4'd9,
    STRM_B2     = 4'd10,
    STRM_B3     = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] PWR_END  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_END = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PKT_END  = CNT_W'(PKT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       stat_sh;
  logic [7:0]       dx_sh;
  logic             good;
  logic             resp_to;
  logic             pkt_to;
  logic             restart;
  logic             publish;
  logic             latch_s;
  logic             latch_dx;

  function automatic logic rd_of(input state_t s);
    return (s == WAIT_FA) || (s == WAIT_AA) || (s == WAIT_ID) ||
           (s == WAIT_FA_EN) || (s == STRM_B1) ||
           (s == STRM_B2) || (s == STRM_B3);
  endfunction

  function automatic logic strm_of(input state_t s);
    return (s == STRM_B1) || (s == STRM_B2) || (s == STRM_B3);
  endfunction

  always_comb begin
    good     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    resp_to  = (cnt == RESP_END);
    pkt_to   = (cnt == PKT_END);
    nxt      = state;
    restart  = 1'b0;
    publish  = 1'b0;
    latch_s  = 1'b0;
    latch_dx = 1'b0;
    case (state)
      PWRUP: begin
        if (cnt == PWR_END) nxt = SEND_RST;
      end
      SEND_RST: nxt = WAIT_TX_RST;
      WAIT_TX_RST: begin
        if (BYTE_SENT)    nxt = WAIT_FA;
        else if (resp_to) restart = 1'b1;
      end
      WAIT_FA: begin
        if (BYTE_READY) begin
          if (good && BYTE_READ == 8'hFA) nxt = WAIT_AA;
          else                            restart = 1'b1;
        end else if (resp_to) begin
          restart = 1'b1;
        end
      end
      WAIT_AA: begin
        if (BYTE_READY) begin
          if (good && BYTE_READ == 8'hAA) nxt = WAIT_ID;
          else                            restart = 1'b1;
        end else if (resp_to) begin
          restart = 1'b1;
        end
      end
      WAIT_ID: begin
        if (BYTE_READY) begin
          if (good && BYTE_READ == 8'h00) nxt = SEND_EN;
          else                            restart = 1'b1;
        end else if (resp_to) begin
          restart = 1'b1;
        end
      end
      SEND_EN: nxt = WAIT_TX_EN;
      WAIT_TX_EN: begin
        if (BYTE_SENT)    nxt = WAIT_FA_EN;
        else if (resp_to) restart = 1'b1;
      end
      WAIT_FA_EN: begin
        if (BYTE_READY) begin
          if (good && BYTE_READ == 8'hFA) nxt = STRM_B1;
          else                            restart = 1'b1;
        end else if (resp_to) begin
          restart = 1'b1;
        end
      end
      // Bit 3 of a status byte is always 1; use it to find packet start.
      STRM_B1: begin
        if (good && BYTE_READ[3]) begin
          latch_s = 1'b1;
          nxt     = STRM_B2;
        end
      end
      STRM_B2: begin
        if (BYTE_READY) begin
          if (good) begin
            latch_dx = 1'b1;
            nxt      = STRM_B3;
          end else begin
            nxt = STRM_B1;
          end
        end else if (pkt_to) begin
          nxt = STRM_B1;
        end
      end
      STRM_B3: begin
        if (BYTE_READY) begin
          publish = good;
          nxt     = STRM_B1;
        end else if (pkt_to) begin
          nxt = STRM_B1;
        end
      end
      default: nxt = PWRUP;
    endcase
    if (restart) nxt = SEND_RST;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= PWRUP;
      cnt            <= '0;
      stat_sh        <= 8'h00;
      dx_sh          <= 8'h00;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      SEND_INTERRUPT <= 1'b0;
      INIT_DONE      <= 1'b0;
      RETRY_COUNT    <= 4'd0;
      MASTER_STATE   <= 4'd0;
    end else begin
      state <= nxt;
      if ((nxt != state) || (BYTE_READY && rd_of(state)))
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
      // Command byte is held until the next command is issued.
      SEND_BYTE <= (nxt == SEND_RST) || (nxt == SEND_EN);
      if (nxt == SEND_RST)
        BYTE_TO_SEND <= 8'hFF;
      else if (nxt == SEND_EN)
        BYTE_TO_SEND <= 8'hF4;
      READ_ENABLE  <= rd_of(nxt);
      INIT_DONE    <= strm_of(nxt);
      MASTER_STATE <= nxt;
      if (restart && RETRY_COUNT != 4'd15)
        RETRY_COUNT <= RETRY_COUNT + 4'd1;
      if (latch_s)  stat_sh <= BYTE_READ;
      if (latch_dx) dx_sh   <= BYTE_READ;
      SEND_INTERRUPT <= publish;
      if (publish) begin
        MOUSE_STATUS <= stat_sh;
        MOUSE_DX     <= dx_sh;
        MOUSE_DY     <= BYTE_READ;
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: init handshake, packets,
// sync/error handling, timeouts, init retries and mid-packet reset.
module tb_mouse_master_sm;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_sent;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       read_enable;
  logic [7:0] mouse_status;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic       send_interrupt;
  logic       init_done;
  logic [3:0] retry_count;
  logic [3:0] master_state;

  int checks   = 0;
  int failures = 0;

  mouse_master_sm #(
    .POWERUP_CYCLES(10),
    .RESP_TIMEOUT  (50),
    .PKT_TIMEOUT   (20),
    .CNT_W         (26)
  ) dut (
    .CLK            (clk),
    .RESET          (reset),
    .BYTE_SENT      (byte_sent),
    .BYTE_READ      (byte_read),
    .BYTE_ERROR_CODE(byte_error_code),
    .BYTE_READY     (byte_ready),
    .SEND_BYTE      (send_byte),
    .BYTE_TO_SEND   (byte_to_send),
    .READ_ENABLE    (read_enable),
    .MOUSE_STATUS   (mouse_status),
    .MOUSE_DX       (mouse_dx),
    .MOUSE_DY       (mouse_dy),
    .SEND_INTERRUPT (send_interrupt),
    .INIT_DONE      (init_done),
    .RETRY_COUNT    (retry_count),
    .MASTER_STATE   (master_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    byte_read       = b;
    byte_error_code = e;
    byte_ready      = 1'b1;
    step();
    byte_ready      = 1'b0;
    byte_error_code = 2'b00;
  endtask

  task automatic sent();
    byte_sent = 1'b1;
    step();
    byte_sent = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    byte_sent       = 1'b0;
    byte_read       = 8'h00;
    byte_error_code = 2'b00;
    byte_ready      = 1'b0;
    step();
    step();
    chk("rst_send", send_byte, 0);
    chk("rst_tx", byte_to_send, 8'h00);
    chk("rst_rden", read_enable, 0);
    chk("rst_irq", send_interrupt, 0);
    chk("rst_done", init_done, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_state", master_state, 0);
    chk("rst_status", mouse_status, 0);

    // clean init
    reset = 1'b0;
    repeat (9) step();
    chk("pwr_early", send_byte, 0);
    step();
    chk("pwr_send", send_byte, 1);
    chk("pwr_ff", byte_to_send, 8'hFF);
    chk("pwr_state", master_state, 1);
    step();
    chk("txrst_state", master_state, 2);
    chk("txrst_pulse", send_byte, 0);
    chk("txrst_hold", byte_to_send, 8'hFF);
    sent();
    chk("fa_state", master_state, 3);
    chk("fa_rden", read_enable, 1);
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    chk("en_state", master_state, 6);
    chk("en_send", send_byte, 1);
    chk("en_f4", byte_to_send, 8'hF4);
    step();
    chk("txen_state", master_state, 7);
    sent();
    chk("faen_state", master_state, 8);
    rx(8'hFA, 2'b00);
    chk("init_done", init_done, 1);
    chk("init_retry", retry_count, 0);
    chk("init_state", master_state, 9);

    // first packet
    rx(8'h08, 2'b00);
    chk("pk1_b2", master_state, 10);
    rx(8'h05, 2'b00);
    chk("pk1_b3", master_state, 11);
    chk("pk1_noirq", send_interrupt, 0);
    rx(8'hFB, 2'b00);
    chk("pk1_irq", send_interrupt, 1);
    chk("pk1_status", mouse_status, 8'h08);
    chk("pk1_dx", mouse_dx, 8'h05);
    chk("pk1_dy", mouse_dy, 8'hFB);
    chk("pk1_state", master_state, 9);
    step();
    chk("pk1_irq_off", send_interrupt, 0);

    // sync and error bytes
    rx(8'h00, 2'b00);
    chk("sync_stay", master_state, 9);
    rx(8'h09, 2'b00);
    chk("sync_b2", master_state, 10);
    rx(8'h12, 2'b01);
    chk("err_state", master_state, 9);
    chk("err_irq", send_interrupt, 0);
    chk("err_status", mouse_status, 8'h08);
    chk("err_dx", mouse_dx, 8'h05);
    chk("err_dy", mouse_dy, 8'hFB);

    // packet timeout
    rx(8'h08, 2'b00);
    repeat (19) step();
    chk("pto_before", master_state, 10);
    step();
    chk("pto_after", master_state, 9);
    chk("pto_irq", send_interrupt, 0);
    rx(8'h18, 2'b00);
    rx(8'h01, 2'b00);
    rx(8'h02, 2'b00);
    chk("pk2_irq", send_interrupt, 1);
    chk("pk2_status", mouse_status, 8'h18);
    chk("pk2_dx", mouse_dx, 8'h01);
    chk("pk2_dy", mouse_dy, 8'h02);

    // reset mid-packet
    rx(8'h08, 2'b00);
    rx(8'h05, 2'b00);
    reset = 1'b1;
    step();
    chk("mrst_state", master_state, 0);
    chk("mrst_status", mouse_status, 0);
    chk("mrst_dx", mouse_dx, 0);
    chk("mrst_dy", mouse_dy, 0);
    chk("mrst_done", init_done, 0);
    chk("mrst_rden", read_enable, 0);
    reset = 1'b0;
    rx(8'h02, 2'b00);
    chk("mrst_ignore", master_state, 0);
    repeat (8) step();
    chk("reinit_early", send_byte, 0);
    step();
    chk("reinit_send", send_byte, 1);
    chk("reinit_ff", byte_to_send, 8'hFF);

    // init failure: FC where AA expected
    step();
    sent();
    rx(8'hFA, 2'b00);
    chk("bad_wait_aa", master_state, 4);
    rx(8'hFC, 2'b00);
    chk("bad_state", master_state, 1);
    chk("bad_retry", retry_count, 1);
    chk("bad_send", send_byte, 1);
    chk("bad_ff", byte_to_send, 8'hFF);
    chk("bad_done", init_done, 0);

    // response timeout in WAIT_FA
    step();
    sent();
    chk("rto_wait", master_state, 3);
    repeat (49) step();
    chk("rto_before", master_state, 3);
    step();
    chk("rto_state", master_state, 1);
    chk("rto_retry", retry_count, 2);
    chk("rto_send", send_byte, 1);
    chk("rto_keep_dy", mouse_dy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
Controller that sequences the PS/2 mouse byte receiver and byte transmitter. It runs the power-up and initialisation handshake (reset, self-test, enable streaming), then assembles 3-byte movement packets into registered status/DX/DY outputs with a one-cycle interrupt. It gates the receiver via READ_ENABLE, drives the transmitter via SEND_BYTE, and retries initialisation on error or timeout.

Parameters:
POWERUP_CYCLES, 1000000, idle cycles after reset before the first command (10 ms at 100 MHz)
RESP_TIMEOUT, 50000000, max cycles in any init wait state before restart
PKT_TIMEOUT, 200000, max cycles between bytes 2/3 of one packet before resync
CNT_W, 26, width of the shared timeout counter; must hold the largest parameter

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
BYTE_SENT  in  1  transmitter done pulse, one cycle
BYTE_READ  in  8  receiver data byte
BYTE_ERROR_CODE  in  2  receiver status; bit0 parity error, bit1 stop-bit error
BYTE_READY  in  1  receiver byte-valid pulse, one cycle
SEND_BYTE  out  1  one-cycle request to the transmitter
BYTE_TO_SEND  out  8  command byte; stable from the SEND_BYTE cycle until BYTE_SENT
READ_ENABLE  out  1  receiver enable
MOUSE_STATUS  out  8  byte 1 of last valid packet
MOUSE_DX  out  8  byte 2 of last valid packet
MOUSE_DY  out  8  byte 3 of last valid packet
SEND_INTERRUPT  out  1  one-cycle pulse when a new packet is published
INIT_DONE  out  1  high while in streaming states
RETRY_COUNT  out  4  init restarts since reset, saturates at 15
MASTER_STATE  out  4  current state encoding, debug

Behaviour:
- Reset values: all outputs 0. State is PWRUP. Timeout counter is 0.
- Timeout counter increments every cycle. It clears on every state change and on every accepted BYTE_READY.
- States and transitions:
  - PWRUP(0): when count == POWERUP_CYCLES-1, go to SEND_RST.
  - SEND_RST(1): SEND_BYTE=1 and BYTE_TO_SEND=8'hFF for exactly this cycle, then go to WAIT_TX_RST.
  - WAIT_TX_RST(2): on BYTE_SENT, go to WAIT_FA.
  - WAIT_FA(3), WAIT_AA(4), WAIT_ID(5): on BYTE_READY, the byte is accepted only if BYTE_ERROR_CODE==0 and BYTE_READ equals FA, AA or 00 respectively. On acceptance, advance to the next state. On a wrong value or a nonzero error code, restart.
  - SEND_EN(6): SEND_BYTE=1 with BYTE_TO_SEND=8'hF4 for one cycle, then go to WAIT_TX_EN(7).
  - WAIT_TX_EN(7): on BYTE_SENT, go to WAIT_FA_EN(8).
  - WAIT_FA_EN(8): expects FA, error-free. On success go to STRM_B1; otherwise restart.
  - STRM_B1(9): on BYTE_READY with error==0 and BYTE_READ[3]==1, latch the byte into a status shadow register and go to STRM_B2. Otherwise stay (packet sync). No timeout applies in this state.
  - STRM_B2(10): on a good byte, latch the dx shadow and go to STRM_B3. On an error byte or timeout, go to STRM_B1.
  - STRM_B3(11): on a good byte, the next cycle copies both shadows plus this byte to MOUSE_STATUS/DX/DY and SEND_INTERRUPT=1 for that same cycle; state returns to STRM_B1. On an error byte or timeout, go to STRM_B1 with outputs unchanged.
- Restart means: go to SEND_RST, skipping PWRUP, and increment RETRY_COUNT (saturating). Any init wait state (2–8) restarts when count reaches RESP_TIMEOUT-1.
- READ_ENABLE=1 in states 3,4,5,8,9,10,11; 0 otherwise. BYTE_READY outside these states is ignored.
- INIT_DONE=1 in states 9–11.
- MOUSE_* outputs hold their values between packets and across restarts; only RESET clears them.
- BYTE_SENT received outside a WAIT_TX state is ignored.
- RESET has priority over every event, including mid-transmit and mid-packet. It returns the block to PWRUP and clears RETRY_COUNT.
- Unused state encodings go to PWRUP.

Test Plan:
- Clean init (POWERUP_CYCLES=10): SEND_BYTE carries FF exactly 10 cycles after reset; supply BYTE_SENT, then FA, AA, 00. SEND_BYTE then carries F4; supply BYTE_SENT and FA. Required: INIT_DONE=1 and RETRY_COUNT=0.
- Packet: after init, send bytes 08, 05, FB. One cycle after the third BYTE_READY, MOUSE_STATUS=08, MOUSE_DX=05, MOUSE_DY=FB and SEND_INTERRUPT pulses high for exactly one cycle.
- Sync and errors: in streaming, send 00 (bit3=0), which is ignored. Then send 09, then 12 with BYTE_ERROR_CODE=01. Required: state=STRM_B1, no interrupt, outputs keep 08/05/FB.
- Init failure: answer FF with FC instead of AA. Required: restart at SEND_RST, RETRY_COUNT=1, FF resent. Then respond with no bytes (RESP_TIMEOUT=50): restart again after 50 cycles in WAIT_FA, RETRY_COUNT=2.
- Packet timeout (PKT_TIMEOUT=20): send 08, then nothing for 20 cycles. Required: return to STRM_B1. A following 18, 01, 02 sequence publishes those three values.
- Reset mid-packet: assert RESET between bytes 2 and 3. Required: the next cycle has all outputs 0 and state=PWRUP, and a full re-init is needed.
